serial_bit_feeder: RTL and testbench



---
 rtl/serial_pkg.sv | 34 +++
 rtl/serial_bit_feeder_piso_shreg.sv | 55 +++++
 rtl/serial_bit_feeder.sv | 177 +++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial feeder blocks:
//   - state_t     : FSM state encoding (IDLE/SHIFT/GAP, 2 bits; 2'b11 illegal)
//   - GAP_CNT_W   : width of the inter-word gap counter (covers GAP 0..15)
//   - clog2_safe  : ceil(log2(n)), never less than 1, usable for port widths
// -----------------------------------------------------------------------------
package serial_pkg;

  // The ST_ prefix keeps the state names clear of the GAP parameter on the top.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int GAP_MAX   = 15;
  localparam int GAP_CNT_W = 4;

  // ceil(log2(n)) clamped to at least 1 so a counter never collapses to 0 bits.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
// WIDTH-bit parallel-load / serial-shift register. Load wins over shift.
// Shifting moves data toward the output end and fills with zeros, so once a
// word has been fully shifted out the register (and out_bit) reads zero.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (clears the register)
//   load     in   capture din this edge
//   shift_en in   shift one position toward the output end this edge
//   din      in   WIDTH-bit parallel word
//   out_bit  out  bit currently at the output end (MSB or LSB per MSB_FIRST)
// -----------------------------------------------------------------------------
module piso_shreg
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shifted_s;

  // Next contents after one shift toward the output end, zero-filled.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
      assign out_bit   = shreg_r[WIDTH-1];
    end else begin : g_lsb
      assign shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
      assign out_bit   = shreg_r[0];
    end
  endgenerate

  // Shift register storage: reset, load, shift or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      shreg_r <= din;
    end else if (shift_en) begin
      shreg_r <= shifted_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
// Parallel-in / serial-out feeder for the serial sequence-detector FSMs. Takes
// a WIDTH-bit word over valid/ready, drives it out one bit per clock on x, then
// forces GAP zero cycles so the downstream detector settles back to idle.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (drops any word / gap)
//   din        in   WIDTH-bit word to serialize
//   din_valid  in   din holds a word
//   din_ready  out  word accepted at this edge if din_valid is high
//   x          out  serial bit to the downstream FSM
//   x_valid    out  x carries a data bit (SHIFT only)
//   bit_idx    out  index of the bit on x within its word (0 = first sent)
//   busy       out  FSM is not idle
// All outputs come from flops; nothing on din/din_valid reaches an output
// without passing through a register first.
// -----------------------------------------------------------------------------
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     x,
  output logic                     x_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy
);

  localparam int IDX_W = clog2_safe(WIDTH);

  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_PRELST = IDX_W'(WIDTH - 2);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  // Only with no gap may the next word be taken on the last bit of the current.
  localparam bit                   STREAMING  = (GAP == 0);

  state_t               state_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [GAP_CNT_W-1:0] gap_cnt_r;
  logic                 din_ready_r;
  logic                 x_valid_r;
  logic                 busy_r;

  logic                 hs_s;
  logic                 last_bit_s;
  logic                 shift_en_s;
  logic                 sh_out_s;

  // Handshake and position decodes, all from registered state.
  always_comb begin
    hs_s       = din_valid & din_ready_r;
    last_bit_s = (bit_idx_r == IDX_LAST);
    if (state_r == ST_SHIFT) begin
      shift_en_s = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (hs_s),
    .shift_en (shift_en_s),
    .din      (din),
    .out_bit  (sh_out_s)
  );

  // Control FSM with bit/gap counters; outputs are set for the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_idx_r   <= {IDX_W{1'b0}};
      gap_cnt_r   <= {GAP_CNT_W{1'b0}};
      din_ready_r <= 1'b1;
      x_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          gap_cnt_r <= {GAP_CNT_W{1'b0}};
          bit_idx_r <= {IDX_W{1'b0}};
          if (hs_s) begin
            state_r     <= ST_SHIFT;
            din_ready_r <= 1'b0;
            x_valid_r   <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            din_ready_r <= 1'b1;
            x_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (last_bit_s) begin
            bit_idx_r <= {IDX_W{1'b0}};
            if (hs_s) begin
              // Back-to-back reload: stay in SHIFT with the new word.
              state_r     <= ST_SHIFT;
              gap_cnt_r   <= {GAP_CNT_W{1'b0}};
              din_ready_r <= 1'b0;
              x_valid_r   <= 1'b1;
              busy_r      <= 1'b1;
            end else if (GAP > 0) begin
              state_r     <= ST_GAP;
              gap_cnt_r   <= GAP_LOAD;
              din_ready_r <= 1'b0;
              x_valid_r   <= 1'b0;
              busy_r      <= 1'b1;
            end else begin
              state_r     <= ST_IDLE;
              gap_cnt_r   <= {GAP_CNT_W{1'b0}};
              din_ready_r <= 1'b1;
              x_valid_r   <= 1'b0;
              busy_r      <= 1'b0;
            end
          end else begin
            state_r     <= ST_SHIFT;
            bit_idx_r   <= bit_idx_r + IDX_W'(1);
            gap_cnt_r   <= {GAP_CNT_W{1'b0}};
            // Ready rises together with the last bit appearing on x.
            din_ready_r <= STREAMING && (bit_idx_r == IDX_PRELST);
            x_valid_r   <= 1'b1;
            busy_r      <= 1'b1;
          end
        end

        ST_GAP: begin
          bit_idx_r <= {IDX_W{1'b0}};
          x_valid_r <= 1'b0;
          if (gap_cnt_r == {GAP_CNT_W{1'b0}}) begin
            state_r     <= ST_IDLE;
            gap_cnt_r   <= {GAP_CNT_W{1'b0}};
            din_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r     <= ST_GAP;
            gap_cnt_r   <= gap_cnt_r - GAP_CNT_W'(1);
            din_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end

        default: begin
          // Illegal encoding: fall back to a clean idle.
          state_r     <= ST_IDLE;
          bit_idx_r   <= {IDX_W{1'b0}};
          gap_cnt_r   <= {GAP_CNT_W{1'b0}};
          din_ready_r <= 1'b1;
          x_valid_r   <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Register bit is already zero outside SHIFT; the gate makes x=0 explicit.
  assign x         = sh_out_s & x_valid_r;
  assign x_valid   = x_valid_r;
  assign din_ready = din_ready_r;
  assign busy      = busy_r;
  assign bit_idx   = bit_idx_r;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
// Three feeders (WIDTH=8) share one input stream:
//   d0: MSB first, GAP=2   d1: LSB first, GAP=15   d2: MSB first, GAP=0
// A word-level model per instance tracks "cycles since the word was accepted"
// and derives every expected output from that position.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;

  wire [2:0] rdy_w;
  wire [2:0] x_w;
  wire [2:0] xv_w;
  wire [2:0] busy_w;
  wire [2:0] idx0_w;
  wire [2:0] idx1_w;
  wire [2:0] idx2_w;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state per instance.
  bit       m_busy [3];
  int       m_pos  [3];
  logic [7:0] m_word [3];
  bit       p_msb  [3] = '{1'b1, 1'b0, 1'b1};
  int       p_gap  [3] = '{2, 15, 0};

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_w[0]), .x(x_w[0]), .x_valid(xv_w[0]),
    .bit_idx(idx0_w), .busy(busy_w[0]));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(15)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_w[1]), .x(x_w[1]), .x_valid(xv_w[1]),
    .bit_idx(idx1_w), .busy(busy_w[1]));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_w[2]), .x(x_w[2]), .x_valid(xv_w[2]),
    .bit_idx(idx2_w), .busy(busy_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input int i);
    return !m_busy[i] || (m_pos[i] == 7 && p_gap[i] == 0);
  endfunction

  // Advance model by one edge using the inputs presented at that edge.
  task automatic model_edge(input int i);
    bit hs;
    hs = din_valid && model_ready(i);
    if (rst) begin
      m_busy[i] = 1'b0;
      m_pos[i]  = 0;
    end else if (hs) begin
      m_busy[i] = 1'b1;
      m_pos[i]  = 0;
      m_word[i] = din;
    end else if (m_busy[i]) begin
      m_pos[i] = m_pos[i] + 1;
      if (m_pos[i] == 8 + p_gap[i]) m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_dut(input int i);
    logic e_x, e_xv, e_rdy, e_busy;
    logic [2:0] o_idx;
    int bitpos;
    o_idx = (i == 0) ? idx0_w : (i == 1) ? idx1_w : idx2_w;
    if (!m_busy[i]) begin
      e_x = 1'b0; e_xv = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
    end else if (m_pos[i] < 8) begin
      bitpos = p_msb[i] ? (7 - m_pos[i]) : m_pos[i];
      e_x = m_word[i][bitpos]; e_xv = 1'b1; e_busy = 1'b1;
      e_rdy = (m_pos[i] == 7 && p_gap[i] == 0);
    end else begin
      e_x = 1'b0; e_xv = 1'b0; e_rdy = 1'b0; e_busy = 1'b1;
    end
    chk($sformatf("d%0d.x", i),         32'(x_w[i]),    32'(e_x));
    chk($sformatf("d%0d.x_valid", i),   32'(xv_w[i]),   32'(e_xv));
    chk($sformatf("d%0d.din_ready", i), 32'(rdy_w[i]),  32'(e_rdy));
    chk($sformatf("d%0d.busy", i),      32'(busy_w[i]), 32'(e_busy));
    if (e_xv) chk($sformatf("d%0d.bit_idx", i), 32'(o_idx), 32'(m_pos[i]));
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; din_valid = v; din = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) check_dut(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] d2_pat;
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0; m_pos[i] = 0; m_word[i] = 8'h00;
    end
    d2_pat = 8'hD2;

    // Reset then idle.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(3);

    // Single word 8'hD2: d0 MSB-first with gap, d1 LSB-first, d2 no gap.
    step(1'b0, 1'b1, 8'hD2);
    chk("d0.first_bit", 32'(x_w[0]), 32'(d2_pat[7]));
    chk("d1.first_bit", 32'(x_w[1]), 32'(d2_pat[0]));
    idle(9);
    chk("d0.ready_cycle10", 32'(rdy_w[0]), 32'd0);
    idle(1);
    chk("d0.ready_cycle11", 32'(rdy_w[0]), 32'd1);
    idle(15);

    // Stall: valid pulses while shifting / in gap are ignored (d2 may accept).
    step(1'b0, 1'b1, 8'h3C);
    for (int k = 0; k < 20; k++) step(1'b0, (k % 3) == 0, 8'($urandom));
    idle(25);

    // Back-to-back with valid held: FF then 00.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h00);
    idle(25);

    // Reset mid-word at bit_idx 3, then a clean word.
    step(1'b0, 1'b1, 8'h5A);
    idle(3);
    chk("d0.idx_before_rst", 32'(idx0_w), 32'd3);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    idle(25);

    // Reset has priority over a handshake at the same edge.
    step(1'b1, 1'b1, 8'hFF);
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(63) == 0, $urandom_range(2) == 0, 8'($urandom));
    end
    idle(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
